alu_arbiter: RTL

Round-robin scheduler that shares one combinational ALU instance between two requesters.
- Each requester presents operands and an operation on a valid/ready interface.
- The block grants one requester, registers its operands into the ALU, captures the ALU result one cycle later, and holds it on a single response interface tagged with the requester ID until it is accepted.
- Sits between command sources (e.g. two sequencers or a host port) and the ALU datapath.

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional ALU_ARB_STATS_EN adds saturating handshake and error counters.
package alu_arbiter_pkg;
    typedef enum logic [2:0] {
        Operation_ADD = 3'd0,
        Operation_SUB = 3'd1,
        Operation_MUL = 3'd2,
        Operation_DIV = 3'd3,
        Operation_AND = 3'd4,
        Operation_OR  = 3'd5,
        Operation_XOR = 3'd6,
        Operation_NOP = 3'd7
    } operation_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req0_in1,
    input  logic [WIDTH-1:0]   req0_in2,
    input  operation_t         req0_op,
    input  logic [WIDTH-1:0]   req1_in1,
    input  logic [WIDTH-1:0]   req1_in2,
    input  operation_t         req1_op,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    output operation_t         alu_op,
    output logic               alu_nvalid_data,
    input  logic [2*WIDTH-1:0] alu_out,
    input  logic               alu_zero,
    input  logic               alu_error,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_zero,
    output logic               rsp_error
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        stat_ops0,
    output logic [15:0]        stat_ops1,
    output logic [15:0]        stat_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] grant;
    logic       last_grant;
    logic       rsp_hs;

    assign rsp_hs = (state_q == HOLD) && rsp_valid && rsp_ready;

    // Under contention the requester not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            if (req_valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready       = grant;
    assign alu_nvalid_data = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|grant) state_d = EXEC;
            EXEC:    state_d = HOLD;
            HOLD:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_op     <= Operation_ADD;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_error  <= 1'b0;
        end else begin
            if (grant[0]) begin
                alu_in1    <= req0_in1;
                alu_in2    <= req0_in2;
                alu_op     <= req0_op;
                last_grant <= 1'b0;
                rsp_id     <= 1'b0;
            end else if (grant[1]) begin
                alu_in1    <= req1_in1;
                alu_in2    <= req1_in2;
                alu_op     <= req1_op;
                last_grant <= 1'b1;
                rsp_id     <= 1'b1;
            end
            if (state_q == EXEC) begin
                rsp_data  <= alu_out;
                rsp_zero  <= alu_zero;
                rsp_error <= alu_error;
                rsp_valid <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_err  <= '0;
        end else if (rsp_hs) begin
            if (!rsp_id && stat_ops0 != 16'hFFFF) begin
                stat_ops0 <= stat_ops0 + 16'd1;
            end
            if (rsp_id && stat_ops1 != 16'hFFFF) begin
                stat_ops1 <= stat_ops1 + 16'd1;
            end
            if (rsp_error && stat_err != 16'hFFFF) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end
`endif

endmodule
